wb_timer: RTL
=============

WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 Parameter RESET_MTIMECMP, default 64'hFFFF_FFFF_FFFF_FFFF, reset value of the compare register.
REQ-002 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 adr_i  input  32  byte address; only adr_i[4:2] decoded, upper bits ignored (interconnect gates stb_i).
REQ-005 dat_i  input  32  write data.
REQ-006 dat_o  output  32  read data; valid only while ack_o=1, 0 otherwise.
REQ-007 sel_i  input  4  byte enables for writes; bit n covers dat_i[8n+7:8n].
REQ-008 we_i  input  1  1=write, 0=read.
REQ-009 stb_i, cyc_i  input  1 each  Wishbone classic strobe and cycle.
REQ-010 ack_o  output  1  normal termination, one-cycle pulse.
REQ-011 err_o  output  1  error termination, one-cycle pulse.
REQ-012 rty_o  output  1  tied 0.
REQ-013 timer_interrupt  output  1  level interrupt request to the CPU.

Function
REQ-014 Register map (adr_i[4:2]): 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL (bit0 EN, bit1 IE, others read 0), 5 PRESCALE (32-bit); 6,7 unmapped.
REQ-015 Request accepted on an edge where cyc_i=1, stb_i=1, ack_o=0, err_o=0; exactly one wait state: ack_o or err_o high the following cycle for one cycle only.
REQ-016 Master holding stb_i after termination: next request accepted on the edge the pulse ends, so terminations never occur on consecutive cycles.
REQ-017 stb_i/cyc_i dropped after acceptance: termination pulse still issued; no abort.
REQ-018 Writes take effect at the accepting edge, only on bytes with sel_i set; sel_i=0 write is acked with no change.
REQ-019 Unmapped address (read or write): err_o instead of ack_o, no state change, dat_o=0.
REQ-020 Reads ignore sel_i and return the full 32-bit word as of the accepting edge.
REQ-021 Reading MTIME_LO latches MTIME_HI into a shadow register at the same edge; reading MTIME_HI returns the shadow (atomic 64-bit read, LO then HI).
REQ-022 Prescaler: 32-bit counter; when EN=1 it increments each cycle; when it equals PRESCALE it returns to 0 and mtime increments by 1; PRESCALE=0 means mtime increments every cycle.
REQ-023 EN=0: prescaler and mtime hold.
REQ-024 mtime is 64-bit unsigned and wraps 2^64-1 -> 0 without a flag.
REQ-025 Write to MTIME_LO or MTIME_HI: that cycle's increment suppressed, prescaler cleared to 0, unwritten bytes keep pre-edge value.
REQ-026 Write to PRESCALE clears prescaler counter.
REQ-027 timer_interrupt is registered: equals IE && (mtime >= mtimecmp, 64-bit unsigned) evaluated on previous-cycle register values (one-cycle latency).
REQ-028 Interrupt cleared only by writing mtimecmp above mtime, writing mtime, or clearing IE; no sticky pending bit.

Reset
REQ-029 While rst_i=0: ack_o=0, err_o=0, dat_o=0, timer_interrupt=0 immediately (asynchronously).
REQ-030 Reset values: mtime=0, shadow=0, prescaler=0, PRESCALE=0, CTRL=0, mtimecmp=RESET_MTIMECMP.
REQ-031 Reset mid-transaction: accepted request discarded, no termination issued after release.
REQ-032 First request accepted on the first rising edge with rst_i=1.

Verification
REQ-033 Write CTRL=1, PRESCALE=0; after 10 cycles read MTIME_LO -> value within the 10-13 window, ack_o exactly 1 cycle after acceptance.
REQ-034 Preload MTIME=0x0000_0000_FFFF_FFFF (EN=1, PRESCALE=0); read LO then HI -> HI returns shadow matching LO (0 if LO read before carry, 1 if LO wrapped), never a torn pair.
REQ-035 MTIMECMP=20, CTRL=3, PRESCALE=0, mtime=0 -> timer_interrupt rises exactly one cycle after mtime reaches 20; write MTIMECMP_LO=0xFFFF_FFFF -> falls one cycle later.
REQ-036 Write sel_i=4'b0010, dat_i=0xAABB_CCDD to PRESCALE -> read returns 0x0000_CC00.
REQ-037 Read adr_i=0x18 -> err_o pulse, ack_o=0, dat_o=0; back-to-back held strobe of 3 reads -> 3 ack pulses separated by idle cycles.
REQ-038 Assert rst_i=0 the cycle after a write is accepted -> no ack_o after release, all registers at reset values.

Source files
------------

// File: rtl/wb_timer.sv
// wb_timer: Wishbone classic machine timer with prescaler, 64-bit compare and registered interrupt.
// Every access terminates with exactly one wait state; reads of MTIME_HI return the shadow latched by MTIME_LO.
module wb_timer #(
  parameter logic [63:0] RESET_MTIMECMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  output logic        timer_interrupt
);
  logic [63:0] mtime_q, mtime_d, cmp_q, cmp_d;
  logic [31:0] shadow_q, shadow_d, ps_q, ps_d, pre_q, pre_d, rdat_q, rdat_d, rd, ctrl_w;
  logic        en_q, en_d, ie_q, ie_d, ack_q, ack_d, err_q, err_d, irq_q, irq_d;
  logic [2:0]  a;
  logic        acc, mapped, wr, tick, unused_adr;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int b = 0; b < 4; b++) merge[8*b+:8] = s[b] ? n[8*b+:8] : o[8*b+:8];
  endfunction

  assign a          = adr_i[4:2];
  assign unused_adr = ^{adr_i[31:5], adr_i[1:0]};
  assign mapped     = a < 3'd6;
  assign acc        = cyc_i & stb_i & ~ack_q & ~err_q;
  assign wr         = acc & we_i & mapped & |sel_i;
  assign tick       = en_q & (ps_q == pre_q);
  assign ctrl_w     = merge({30'b0, ie_q, en_q}, dat_i, sel_i);

  always_comb begin
    rd = a == 3'd0 ? mtime_q[31:0] :
         a == 3'd1 ? shadow_q :
         a == 3'd2 ? cmp_q[31:0] :
         a == 3'd3 ? cmp_q[63:32] :
         a == 3'd4 ? {30'b0, ie_q, en_q} :
         a == 3'd5 ? pre_q : 32'b0;
  end

  always_comb begin
    mtime_d  = en_q ? mtime_q + 64'(tick) : mtime_q;
    ps_d     = en_q ? (tick ? 32'b0 : ps_q + 32'd1) : ps_q;
    cmp_d    = cmp_q;
    pre_d    = pre_q;
    en_d     = en_q;
    ie_d     = ie_q;
    shadow_d = (acc & ~we_i & a == 3'd0) ? mtime_q[63:32] : shadow_q;
    // A software write to mtime wins over that cycle's increment and restarts the prescaler
    if (wr && a == 3'd0) begin
      mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], dat_i, sel_i)};
      ps_d    = 32'b0;
    end
    if (wr && a == 3'd1) begin
      mtime_d = {merge(mtime_q[63:32], dat_i, sel_i), mtime_q[31:0]};
      ps_d    = 32'b0;
    end
    if (wr && a == 3'd2) cmp_d[31:0] = merge(cmp_q[31:0], dat_i, sel_i);
    if (wr && a == 3'd3) cmp_d[63:32] = merge(cmp_q[63:32], dat_i, sel_i);
    if (wr && a == 3'd4) begin
      en_d = ctrl_w[0];
      ie_d = ctrl_w[1];
    end
    if (wr && a == 3'd5) begin
      pre_d = merge(pre_q, dat_i, sel_i);
      ps_d  = 32'b0;
    end
    ack_d  = acc & mapped;
    err_d  = acc & ~mapped;
    rdat_d = (acc & ~we_i & mapped) ? rd : 32'b0;
    irq_d  = ie_q & (mtime_q >= cmp_q);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mtime_q  <= '0;
      cmp_q    <= RESET_MTIMECMP;
      shadow_q <= '0;
      ps_q     <= '0;
      pre_q    <= '0;
      rdat_q   <= '0;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      shadow_q <= shadow_d;
      ps_q     <= ps_d;
      pre_q    <= pre_d;
      rdat_q   <= rdat_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      irq_q    <= irq_d;
    end
  end

  assign ack_o           = ack_q;
  assign err_o           = err_q;
  assign rty_o           = 1'b0;
  assign dat_o           = ack_q ? rdat_q : 32'b0;
  assign timer_interrupt = irq_q;
endmodule
